// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_LOAD
    } wb_src_e;

    // NORMAL: pipeline has priority. DRAIN: queued load returns are forced out.
    typedef enum logic {
        ARB_NORMAL,
        ARB_DRAIN
    } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between MEM/WB, the data-memory return path and the register file.
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                  ld_issue;
    logic [REG_ADDR_W-1:0] ld_issue_rd;
    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_ready;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  wb_stall;
    logic                  raw_stall;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wdata;

    // Arbiter side.
    modport slave (
        input  ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
        input  wb_valid, wb_rd, wb_data, rs1, rs2,
        output ld_ready, wb_stall, raw_stall, rf_we, rf_rd, rf_wdata
    );

    // Pipeline / bus / register-file side.
    modport master (
        output ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
        output wb_valid, wb_rd, wb_data, rs1, rs2,
        input  ld_ready, wb_stall, raw_stall, rf_we, rf_rd, rf_wdata
    );

endinterface

// File: rtl/wb_port_arbiter_ret_fifo.sv
// Small {rd,data} FIFO holding load returns that lost the write port.
// Head is read combinationally so it can be written and popped in one cycle.
module wb_ret_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [REG_ADDR_W-1:0]   i_rd,
    input  logic [XLEN-1:0]         i_data,
    output logic [REG_ADDR_W-1:0]   o_head_rd,
    output logic [XLEN-1:0]         o_head_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int PW = $clog2(DEPTH);

    logic [REG_ADDR_W+XLEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]              r_wr_ptr;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW:0]                r_count;

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= {i_rd, i_data};
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= PW'(r_wr_ptr + 1'b1);
            if (i_pop)  r_rd_ptr <= PW'(r_rd_ptr + 1'b1);
            case ({i_push, i_pop})
                2'b10:   r_count <= (PW+1)'(r_count + 1'b1);
                2'b01:   r_count <= (PW+1)'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign {o_head_rd, o_head_data} = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. late load returns,
// with a pending-load scoreboard, WAW/RAW stalls and a starvation-driven drain mode.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [REG_ADDR_W-1:0] w_head_rd;
    logic [XLEN-1:0]       w_head_data;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ld_cand;
    logic [REG_ADDR_W-1:0] w_ld_rd;
    logic [XLEN-1:0]       w_ld_data;
    logic                  w_waw;
    wb_src_e               w_grant;
    logic                  r_sb [32];
    logic [WW-1:0]         r_wait;
    logic [WW-1:0]         w_wait_next;
    arb_state_e            r_state;
    arb_state_e            w_state_next;

    wb_ret_fifo #(.DEPTH(DEPTH)) u_ret_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_rd        (bus.ld_rd),
        .i_data      (bus.ld_data),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // Grant selection, FIFO control and port/stall outputs.
    always_comb begin
        w_ld_cand = !w_fifo_empty || bus.ld_valid;
        w_ld_rd   = w_fifo_empty ? bus.ld_rd   : w_head_rd;
        w_ld_data = w_fifo_empty ? bus.ld_data : w_head_data;
        w_waw     = bus.wb_valid && r_sb[bus.wb_rd] && (bus.wb_rd != '0);

        w_grant = SRC_NONE;
        if (r_state == ARB_NORMAL && bus.wb_valid && !w_waw) begin
            w_grant = SRC_PIPE;
        end else if (w_ld_cand) begin
            w_grant = SRC_LOAD;
        end

        // An empty FIFO with a granted return is a bypass: nothing is enqueued.
        w_pop  = (w_grant == SRC_LOAD) && !w_fifo_empty;
        w_push = bus.ld_valid && !w_fifo_full && !((w_grant == SRC_LOAD) && w_fifo_empty);

        bus.rf_we    = 1'b0;
        bus.rf_rd    = '0;
        bus.rf_wdata = '0;
        if (w_grant == SRC_PIPE && bus.wb_rd != '0) begin
            bus.rf_we    = 1'b1;
            bus.rf_rd    = bus.wb_rd;
            bus.rf_wdata = bus.wb_data;
        end else if (w_grant == SRC_LOAD && w_ld_rd != '0) begin
            bus.rf_we    = 1'b1;
            bus.rf_rd    = w_ld_rd;
            bus.rf_wdata = w_ld_data;
        end

        bus.ld_ready  = !w_fifo_full;
        bus.wb_stall  = bus.wb_valid && (w_waw || r_state == ARB_DRAIN);
        bus.raw_stall = ((bus.rs1 != '0) && r_sb[bus.rs1]) ||
                        ((bus.rs2 != '0) && r_sb[bus.rs2]);
    end

    // Pending-load scoreboard, one flop per register; a new issue beats a same-cycle write.
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        logic w_set;
        logic w_clr;
        assign w_set = bus.ld_issue && (bus.ld_issue_rd == REG_ADDR_W'(gi)) && (gi != 0);
        assign w_clr = (w_grant == SRC_LOAD) && (w_ld_rd == REG_ADDR_W'(gi));
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sb[gi] <= 1'b0;
            end else if (w_set) begin
                r_sb[gi] <= 1'b1;
            end else if (w_clr) begin
                r_sb[gi] <= 1'b0;
            end
        end
    end

    // Starvation counter and NORMAL/DRAIN next state.
    always_comb begin
        w_wait_next  = r_wait;
        w_state_next = r_state;
        if (w_pop) begin
            w_wait_next = '0;
        end else if (!w_fifo_empty && w_grant != SRC_LOAD && r_wait != WW'(MAX_WAIT)) begin
            w_wait_next = WW'(r_wait + 1'b1);
        end
        case (r_state)
            ARB_NORMAL: begin
                if (w_wait_next == WW'(MAX_WAIT)) w_state_next = ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (w_pop && !w_push && w_fifo_count == CW'(1)) begin
                    w_state_next = ARB_NORMAL;
                    w_wait_next  = '0;
                end
            end
            default: w_state_next = ARB_NORMAL;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_NORMAL;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

endmodule
